pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Next-address controller for the ProgramCounter register. Computes PCin
//   each cycle from the current PC and the control decoder's flow requests.
//   Requests are sequential, branch, jump, call and return. Also owns a small
//   return-address stack (RAS) and a RUN/HALT/FAULT state machine that freezes
//   instruction fetch. Sits between the control unit and ProgramCounter.
// PARAMETERS
//   Width      8  PC / address width; all address arithmetic is modulo 2**Width
//   RAS_DEPTH  4  return-address stack entries (power of 2, >=2)
// PORTS
//   CLK           in   1      clock, rising edge
//   Reset         in   1      synchronous, active-high
//   PC            in   Width  current PC, driven by ProgramCounter output
//   Stall         in   1      hold PC this cycle (e.g. memory wait)
//   Branch        in   1      conditional branch instruction
//   BranchTaken   in   1      branch condition true; qualified by Branch
//   BranchOffset  in   Width  signed two's-complement offset, relative to PC+1
//   Jump          in   1      absolute jump to JumpAddr
//   Call          in   1      push PC+1, jump to JumpAddr
//   Ret           in   1      pop RAS top into PC
//   JumpAddr      in   Width  absolute target for Jump/Call
//   Halt          in   1      enter HALT
//   Resume        in   1      leave HALT
//   PCnext        out  Width  drives ProgramCounter.PCin (combinational)
//   State         out  2      RUN=2'b00, HALT=2'b01, FAULT=2'b10 (registered)
//   RasCount      out  log2(RAS_DEPTH)+1  live RAS entries
//   Overflow      out  1      sticky: Call while RAS full
//   Underflow     out  1      sticky: Ret while RAS empty
// BEHAVIOUR
//   Reset (registered outputs):
//   - State=RUN, RasCount=0, Overflow=0, Underflow=0.
//   - RAS contents are don't-care.
//   - Reset dominates every other input, including mid-Call/Ret and in FAULT.
//   - ProgramCounter resets itself to 0, so the first fetch is address 0.
//   PCnext:
//   - Combinational from PC, the request inputs and the RAS top.
//   - Zero-cycle latency: a request seen in cycle N takes effect at PC in
//     cycle N+1.
//   PCnext priority in RUN (first match wins):
//   1. Stall              -> PC; RAS unchanged
//   2. Ret, RAS non-empty -> RAS[top]; pop
//   3. Ret, RAS empty     -> PC; set Underflow; State->FAULT
//   4. Call, RAS not full -> JumpAddr; push PC+1
//   5. Call, RAS full     -> PC; set Overflow; State->FAULT
//   6. Jump               -> JumpAddr
//   7. Branch&BranchTaken -> PC+1+BranchOffset (wraps mod 2**Width)
//   8. otherwise          -> PC+1 (0xFF wraps to 0x00 at Width=8)
//   Priority notes:
//   - BranchTaken without Branch is ignored.
//   - Lower-priority requests in the same cycle are dropped, not queued.
//   HALT state:
//   - Entered from RUN when Halt=1 and Stall=0; that cycle PCnext=PC and no
//     RAS op occurs.
//   - While in HALT: PCnext=PC and all flow requests are ignored.
//   - Resume=1 -> RUN next cycle; Halt has priority if both are high.
//   FAULT state:
//   - PCnext=PC and all requests are ignored.
//   - Left only by Reset; Overflow/Underflow stay set until Reset.
//   RAS:
//   - LIFO; push writes entry[RasCount] and increments; pop reads
//     entry[RasCount-1] and decrements.
//   - Only one operation per cycle; RasCount never exceeds RAS_DEPTH and
//     never goes below 0.
// TESTING
//   1. Reset, then 300 idle cycles (Width=8) -> PC 0,1,..,255,0,1,..
//      Wraps 0xFF->0x00; State=RUN throughout.
//   2. PC=0x10, Branch=1, BranchTaken=1, Offset=0xFC (-4) -> next PC=0x0D.
//      Same with BranchTaken=0 -> 0x11.
//   3. PC=0x20, Call to 0x80 -> PC=0x80, RasCount=1.
//      Then Ret -> PC=0x21, RasCount=0.
//      Call+Ret same cycle with RasCount=0 -> Underflow=1, State=FAULT.
//   4. Five nested Calls (RAS_DEPTH=4) -> fifth asserts Overflow, State=FAULT,
//      PC frozen. Reset -> State=RUN, flags 0, PC=0.
//   5. Halt at PC=0x05 -> PC holds 0x05 for 10 cycles despite Jump.
//      Resume -> PC=0x06 the following cycle.
//   6. Stall with Jump to 0x40 at PC=0x07 -> PC stays 0x07.
//      Reset asserted mid-sequence after 2 pushes -> RasCount=0 next cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-address controller for ProgramCounter: sequential/branch/jump/call/return
// selection, a small return-address stack, and a RUN/HALT/FAULT fetch-freeze FSM.
module pc_sequencer #(
    parameter int Width     = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         Reset,
    input  logic [Width-1:0]             PC,
    input  logic                         Stall,
    input  logic                         Branch,
    input  logic                         BranchTaken,
    input  logic [Width-1:0]             BranchOffset,
    input  logic                         Jump,
    input  logic                         Call,
    input  logic                         Ret,
    input  logic [Width-1:0]             JumpAddr,
    input  logic                         Halt,
    input  logic                         Resume,
    output logic [Width-1:0]             PCnext,
    output logic [1:0]                   State,
    output logic [$clog2(RAS_DEPTH):0]   RasCount,
    output logic                         Overflow,
    output logic                         Underflow
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;
    localparam int IW = CW - 1;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        HALT  = 2'b01,
        FAULT = 2'b10
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic              ovf_q;
    logic              unf_q;
    logic [Width-1:0]  ras_q [RAS_DEPTH];

    logic [Width-1:0]  pc_inc;
    logic [Width-1:0]  pc_d;
    logic [IW-1:0]     top_idx;
    logic [IW-1:0]     push_idx;
    logic              ras_full;
    logic              ras_empty;
    logic              do_push;
    logic              do_pop;
    logic              go_halt;
    logic              go_fault_ovf;
    logic              go_fault_unf;

    assign pc_inc    = PC + Width'(1);
    assign ras_full  = (cnt_q == CW'(RAS_DEPTH));
    assign ras_empty = (cnt_q == '0);
    // Low bits of the count address the slot; a full count wraps to index 0,
    // so subtracting one still lands on the last entry.
    assign push_idx  = cnt_q[IW-1:0];
    assign top_idx   = cnt_q[IW-1:0] - IW'(1);

    always_comb begin
        pc_d         = PC;
        do_push      = 1'b0;
        do_pop       = 1'b0;
        go_halt      = 1'b0;
        go_fault_ovf = 1'b0;
        go_fault_unf = 1'b0;
        if (state_q == RUN) begin
            if (Stall) begin
                pc_d = PC;
            end else if (Halt) begin
                go_halt = 1'b1;
            end else if (Ret) begin
                if (!ras_empty) begin
                    pc_d   = ras_q[top_idx];
                    do_pop = 1'b1;
                end else begin
                    go_fault_unf = 1'b1;
                end
            end else if (Call) begin
                if (!ras_full) begin
                    pc_d    = JumpAddr;
                    do_push = 1'b1;
                end else begin
                    go_fault_ovf = 1'b1;
                end
            end else if (Jump) begin
                pc_d = JumpAddr;
            end else if (Branch && BranchTaken) begin
                pc_d = pc_inc + BranchOffset;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (go_halt) begin
                        state_q <= HALT;
                    end else if (go_fault_ovf) begin
                        state_q <= FAULT;
                        ovf_q   <= 1'b1;
                    end else if (go_fault_unf) begin
                        state_q <= FAULT;
                        unf_q   <= 1'b1;
                    end
                    if (do_push) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else if (do_pop) begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                HALT: begin
                    if (!Halt && Resume) begin
                        state_q <= RUN;
                    end
                end
                FAULT:   state_q <= FAULT;
                default: state_q <= FAULT;
            endcase
        end
    end

    // Stack storage needs no reset: only slots below the count are ever read.
    always_ff @(posedge CLK) begin
        if (!Reset && do_push) begin
            ras_q[push_idx] <= pc_inc;
        end
    end

    assign PCnext    = pc_d;
    assign State     = state_q;
    assign RasCount  = cnt_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic, checked against
// a queue-based behavioural model of the sequencer plus a ProgramCounter register.
module tb_pc_sequencer;
    logic       CLK = 1'b0;
    logic       Reset;
    logic [7:0] PC;
    logic       Stall, Branch, BranchTaken, Jump, Call, Ret, Halt, Resume;
    logic [7:0] BranchOffset, JumpAddr;
    logic [7:0] PCnext;
    logic [1:0] State;
    logic [2:0] RasCount;
    logic       Overflow, Underflow;

    int tests = 0;
    int fails = 0;

    // Model state
    logic [7:0] pc_m;
    int         st_m;
    logic       ovf_m, unf_m;
    logic [7:0] ras_m[$];

    pc_sequencer #(.Width(8), .RAS_DEPTH(4)) dut (
        .CLK(CLK), .Reset(Reset), .PC(PC), .Stall(Stall), .Branch(Branch),
        .BranchTaken(BranchTaken), .BranchOffset(BranchOffset), .Jump(Jump),
        .Call(Call), .Ret(Ret), .JumpAddr(JumpAddr), .Halt(Halt), .Resume(Resume),
        .PCnext(PCnext), .State(State), .RasCount(RasCount),
        .Overflow(Overflow), .Underflow(Underflow)
    );

    always #5 CLK = ~CLK;

    // ProgramCounter stand-in
    always_ff @(posedge CLK) PC <= Reset ? 8'h00 : PCnext;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        Reset = 0; Stall = 0; Branch = 0; BranchTaken = 0; Jump = 0; Call = 0;
        Ret = 0; Halt = 0; Resume = 0; BranchOffset = 8'h00; JumpAddr = 8'h00;
    endtask

    // One clock: model decides, PCnext checked mid-cycle, registered state after the edge.
    task automatic step();
        logic [7:0] exp_next;
        exp_next = pc_m;
        if (Reset) begin
            exp_next = 8'h00;
            st_m = 0; ovf_m = 0; unf_m = 0;
            ras_m.delete();
        end else if (st_m == 0) begin
            if (Stall) exp_next = pc_m;
            else if (Halt) st_m = 1;
            else if (Ret) begin
                if (ras_m.size() > 0) exp_next = ras_m.pop_back();
                else begin unf_m = 1; st_m = 2; end
            end else if (Call) begin
                if (ras_m.size() < 4) begin
                    ras_m.push_back(pc_m + 8'd1);
                    exp_next = JumpAddr;
                end else begin ovf_m = 1; st_m = 2; end
            end else if (Jump) exp_next = JumpAddr;
            else if (Branch && BranchTaken) exp_next = pc_m + 8'd1 + BranchOffset;
            else exp_next = pc_m + 8'd1;
        end else if (st_m == 1) begin
            if (!Halt && Resume) st_m = 0;
        end
        @(negedge CLK);
        if (!Reset) check("pcnext", PCnext, exp_next);
        @(posedge CLK);
        #1;
        pc_m = exp_next;
        check("pc", PC, pc_m);
        check("state", State, st_m);
        check("rascount", RasCount, ras_m.size());
        check("overflow", Overflow, ovf_m);
        check("underflow", Underflow, unf_m);
    endtask

    task automatic do_reset();
        idle(); Reset = 1; step(); idle();
    endtask

    task automatic jump_to(input logic [7:0] a);
        idle(); Jump = 1; JumpAddr = a; step(); idle();
    endtask

    initial begin
        pc_m = 8'h00; st_m = 0; ovf_m = 0; unf_m = 0;
        idle();
        @(posedge CLK); #1;
        // Reset and free-running wrap
        do_reset();
        check("reset_pc", PC, 8'h00);
        check("reset_state", State, 2'b00);
        check("reset_cnt", RasCount, 3'd0);
        for (int i = 0; i < 300; i++) step();
        check("wrap_pc", PC, 8'd44);

        // Branch taken / not taken
        jump_to(8'h10);
        Branch = 1; BranchTaken = 1; BranchOffset = 8'hFC; step(); idle();
        check("br_taken", PC, 8'h0D);
        jump_to(8'h10);
        Branch = 1; BranchTaken = 0; BranchOffset = 8'hFC; step(); idle();
        check("br_not_taken", PC, 8'h11);
        BranchTaken = 1; BranchOffset = 8'h40; step(); idle();
        check("taken_no_branch", PC, 8'h12);

        // Call / Ret / underflow
        jump_to(8'h20);
        Call = 1; JumpAddr = 8'h80; step(); idle();
        check("call_pc", PC, 8'h80);
        check("call_cnt", RasCount, 3'd1);
        Ret = 1; step(); idle();
        check("ret_pc", PC, 8'h21);
        check("ret_cnt", RasCount, 3'd0);
        Call = 1; Ret = 1; JumpAddr = 8'h90; step(); idle();
        check("unf_flag", Underflow, 1'b1);
        check("unf_state", State, 2'b10);
        Jump = 1; JumpAddr = 8'h33; step(); idle();
        check("fault_frozen", PC, 8'h21);

        // Overflow on fifth nested call
        do_reset();
        for (int i = 0; i < 5; i++) begin
            Call = 1; JumpAddr = 8'h40 + 8'(i * 16); step(); idle();
        end
        check("ovf_flag", Overflow, 1'b1);
        check("ovf_state", State, 2'b10);
        check("ovf_pc", PC, 8'h70);
        step();
        check("ovf_frozen", PC, 8'h70);
        do_reset();
        check("ovf_reset_state", State, 2'b00);
        check("ovf_reset_flag", Overflow, 1'b0);
        check("ovf_reset_pc", PC, 8'h00);

        // Halt holds PC despite Jump; Resume returns to RUN
        jump_to(8'h05);
        Halt = 1; step(); idle();
        check("halt_state", State, 2'b01);
        for (int i = 0; i < 10; i++) begin
            Jump = 1; JumpAddr = 8'h99; step(); idle();
        end
        check("halt_pc", PC, 8'h05);
        Halt = 1; Resume = 1; step(); idle();
        check("halt_prio", State, 2'b01);
        Resume = 1; step(); idle();
        check("resume_state", State, 2'b00);
        step();
        check("resume_pc", PC, 8'h06);

        // Stall beats Jump; reset mid-sequence clears the stack
        jump_to(8'h07);
        Stall = 1; Jump = 1; JumpAddr = 8'h40; step(); idle();
        check("stall_pc", PC, 8'h07);
        Stall = 1; Halt = 1; step(); idle();
        check("stall_halt_state", State, 2'b00);
        Call = 1; JumpAddr = 8'h50; step();
        Call = 1; JumpAddr = 8'h60; step(); idle();
        check("two_push_cnt", RasCount, 3'd2);
        Reset = 1; Call = 1; JumpAddr = 8'h70; step(); idle();
        check("mid_reset_cnt", RasCount, 3'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            idle();
            Reset        = ($urandom_range(0, 199) == 0);
            Stall        = ($urandom_range(0, 9) == 0);
            Branch       = ($urandom_range(0, 4) == 0);
            BranchTaken  = $urandom_range(0, 1);
            BranchOffset = 8'($urandom);
            Jump         = ($urandom_range(0, 7) == 0);
            Call         = ($urandom_range(0, 5) == 0);
            Ret          = ($urandom_range(0, 5) == 0);
            JumpAddr     = 8'($urandom);
            Halt         = ($urandom_range(0, 39) == 0);
            Resume       = ($urandom_range(0, 3) == 0);
            step();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
